// File: rtl/m_axil_cmd.sv
// Single-outstanding command-to-AXI4-Lite master bridge.
// Accepts one read or write command, runs it on the AXI4-Lite bus, then returns a one-cycle response with a watchdog abort.
module m_axil_cmd #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  axi_clock,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH+1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,

    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_WIDTH+1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,

    output logic [31:0]           m_axil_wdata,
    output logic [3:0]            m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,

    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,

    output logic [ADDR_WIDTH+1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,

    input  logic [31:0]           m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    localparam int unsigned AW      = ADDR_WIDTH + 2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 32'd0 : TIMEOUT - 32'd1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WADDR_DATA = 3'd1,
        S_WRESP      = 3'd2,
        S_RADDR      = 3'd3,
        S_RDATA      = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [AW-1:0]       r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic                r_aw_done;
    logic                r_w_done;
    logic [CNT_W-1:0]    r_cnt;

    logic                r_cmd_ready;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic [1:0]          r_rsp_resp;

    logic                w_accept;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_ar_hs;
    logic                w_b_hs;
    logic                w_r_hs;
    logic                w_aw_done_eff;
    logic                w_w_done_eff;
    logic                w_active;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_timeout;

    logic                w_cmd_ready_nxt;
    logic                w_awvalid_nxt;
    logic                w_wvalid_nxt;
    logic                w_bready_nxt;
    logic                w_arvalid_nxt;
    logic                w_rready_nxt;
    logic                w_rsp_valid_nxt;
    logic [31:0]         w_rsp_rdata_nxt;
    logic [1:0]          w_rsp_resp_nxt;

    assign w_accept  = (r_state == S_IDLE) && cmd_valid && r_cmd_ready;
    assign w_aw_hs   = r_awvalid && m_axil_awready;
    assign w_w_hs    = r_wvalid && m_axil_wready;
    assign w_ar_hs   = r_arvalid && m_axil_arready;
    assign w_b_hs    = r_bready && m_axil_bvalid;
    assign w_r_hs    = r_rready && m_axil_rvalid;

    // Handshake-done flags only carry meaning while the write phase continues.
    assign w_aw_done_eff = (w_state_nxt == S_WADDR_DATA) && (r_aw_done || w_aw_hs);
    assign w_w_done_eff  = (w_state_nxt == S_WADDR_DATA) && (r_w_done || w_w_hs);

    assign w_active  = (r_state == S_WADDR_DATA) || (r_state == S_WRESP) ||
                       (r_state == S_RADDR)      || (r_state == S_RDATA);
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 16'd1;
    assign w_timeout = w_active && (32'(w_cnt_inc) >= TO_LAST);

    // State register.
    always_ff @(posedge axi_clock or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the watchdog overrides any pending phase.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = cmd_write ? S_WADDR_DATA : S_RADDR;
                end
            end
            S_WADDR_DATA: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_nxt = S_WRESP;
                end
            end
            S_WRESP: begin
                if (w_b_hs) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_RADDR: begin
                if (w_ar_hs) begin
                    w_state_nxt = S_RDATA;
                end
            end
            S_RDATA: begin
                if (w_r_hs) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_timeout) begin
            w_state_nxt = S_DONE;
        end
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        w_cmd_ready_nxt = 1'b0;
        w_awvalid_nxt   = 1'b0;
        w_wvalid_nxt    = 1'b0;
        w_bready_nxt    = 1'b0;
        w_arvalid_nxt   = 1'b0;
        w_rready_nxt    = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;
        case (w_state_nxt)
            S_IDLE:       w_cmd_ready_nxt = 1'b1;
            S_WADDR_DATA: begin
                w_awvalid_nxt = !w_aw_done_eff;
                w_wvalid_nxt  = !w_w_done_eff;
            end
            S_WRESP:      w_bready_nxt    = 1'b1;
            S_RADDR:      w_arvalid_nxt   = 1'b1;
            S_RDATA:      w_rready_nxt    = 1'b1;
            S_DONE:       w_rsp_valid_nxt = 1'b1;
            default:      w_cmd_ready_nxt = 1'b0;
        endcase
        if (w_timeout) begin
            w_rsp_rdata_nxt = 32'd0;
            w_rsp_resp_nxt  = 2'b11;
        end else if ((r_state == S_WRESP) && w_b_hs) begin
            w_rsp_rdata_nxt = 32'd0;
            w_rsp_resp_nxt  = m_axil_bresp;
        end else if ((r_state == S_RDATA) && w_r_hs) begin
            w_rsp_rdata_nxt = m_axil_rdata;
            w_rsp_resp_nxt  = m_axil_rresp;
        end
    end

    // Registered outputs.
    always_ff @(posedge axi_clock or posedge rst) begin
        if (rst) begin
            r_cmd_ready <= 1'b1;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_resp  <= 2'b00;
        end else begin
            r_cmd_ready <= w_cmd_ready_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
        end
    end

    // Command payload, write-phase progress and watchdog counter.
    always_ff @(posedge axi_clock or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
                r_wstrb <= cmd_wstrb;
            end
            r_aw_done <= w_aw_done_eff;
            r_w_done  <= w_w_done_eff;
            if (w_accept) begin
                r_cnt <= '0;
            end else if (w_active) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign cmd_ready      = r_cmd_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_resp       = r_rsp_resp;

    assign m_axil_awaddr  = r_addr;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = r_awvalid;
    assign m_axil_wdata   = r_wdata;
    assign m_axil_wstrb   = r_wstrb;
    assign m_axil_wvalid  = r_wvalid;
    assign m_axil_bready  = r_bready;
    assign m_axil_araddr  = r_addr;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = r_arvalid;
    assign m_axil_rready  = r_rready;

endmodule

// File: tb/tb_m_axil_cmd.sv
// Scoreboard bench for m_axil_cmd: directed commands against a delay-programmable AXI4-Lite slave model.
module tb_m_axil_cmd;

    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    m_axil_cmd #(.ADDR_WIDTH(10), .TIMEOUT(16)) dut (
        .axi_clock(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    logic        s_silent = 1'b0, force_b = 1'b0, force_r = 1'b0;
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        got_aw, got_w, got_ar, s_bvalid, s_rvalid;
    logic [AW-1:0] s_awaddr;
    logic [31:0] s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] mem [16];
    logic        mem_init = 1'b0;

    assign awready = !s_silent && awvalid && (aw_cnt >= aw_delay);
    assign wready  = !s_silent && wvalid  && (w_cnt  >= w_delay);
    assign arready = !s_silent && arvalid && (ar_cnt >= ar_delay);
    assign bvalid  = s_bvalid | force_b;
    assign bresp   = s_bresp;
    assign rvalid  = s_rvalid | force_r;
    assign rdata   = s_rdata;
    assign rresp   = s_rresp;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Word 15 (0x03C) answers SLVERR on both channels.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0;
            s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= 2'b00; s_rresp <= 2'b00;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_rdata <= '0;
            if (!mem_init) begin
                for (int i = 0; i < 16; i++) mem[i] <= '0;
                mem_init <= 1'b1;
            end
        end else begin
            if (awvalid && awready) begin got_aw <= 1'b1; s_awaddr <= awaddr; aw_cnt <= 0; end
            else if (awvalid) aw_cnt <= aw_cnt + 1;
            else aw_cnt <= 0;
            if (wvalid && wready) begin got_w <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; w_cnt <= 0; end
            else if (wvalid) w_cnt <= w_cnt + 1;
            else w_cnt <= 0;
            if (arvalid && arready) begin got_ar <= 1'b1; ar_cnt <= 0; end
            else if (arvalid) ar_cnt <= ar_cnt + 1;
            else ar_cnt <= 0;

            if (s_bvalid) begin
                if (bready) begin
                    s_bvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
                    mem[s_awaddr[5:2]] <= merge(mem[s_awaddr[5:2]], s_wdata, s_wstrb);
                end
            end else if ((got_aw || (awvalid && awready)) && (got_w || (wvalid && wready))) begin
                if (b_cnt >= b_delay) begin
                    s_bvalid <= 1'b1; b_cnt <= 0;
                    s_bresp  <= (((awvalid && awready) ? awaddr[5:2] : s_awaddr[5:2]) == 4'hF) ? 2'b10 : 2'b00;
                end else b_cnt <= b_cnt + 1;
            end

            if (s_rvalid) begin
                if (rready) begin s_rvalid <= 1'b0; got_ar <= 1'b0; end
            end else if (got_ar || (arvalid && arready)) begin
                if (r_cnt >= r_delay) begin
                    s_rvalid <= 1'b1; r_cnt <= 0;
                    s_rdata  <= mem[araddr[5:2]];
                    s_rresp  <= (araddr[5:2] == 4'hF) ? 2'b10 : 2'b00;
                end else r_cnt <= r_cnt + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0;
    int   accept_cyc = 0;
    int   cnt_aw = 0, cnt_w = 0, cnt_b = 0, cnt_rsp = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (awvalid) cnt_aw++;
            if (wvalid) cnt_w++;
            if (bvalid && bready) cnt_b++;
            if (rsp_valid) begin
                cnt_rsp++;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rsp: got rsp_valid with resp %0d rdata 0x%08h, expected none", rsp_resp, rsp_rdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                    chk("rsp_latency", 32'(cyc - accept_cyc), 32'(e.lat));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic push, input logic [31:0] er, input logic [1:0] eresp, input int elat);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        #1;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk); #1; waited++;
        end
        if (!cmd_ready) begin
            vectors++; miscompares++;
            $display("FAIL cmd_accept: got cmd_ready=0 after %0d cycles, expected 1", waited);
            cmd_valid = 1'b0;
            return;
        end
        accept_cyc = cyc;
        if (push) begin
            e.rdata = er; e.resp = eresp; e.lat = elat;
            sb.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL rsp_timeout: got no response within %0d cycles, expected %0d pending", budget, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        int bad;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        #22 rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_awvalid",   32'(awvalid),   32'd0);
        chk("reset_wvalid",    32'(wvalid),    32'd0);
        chk("reset_arvalid",   32'(arvalid),   32'd0);
        chk("reset_bready",    32'(bready),    32'd0);
        chk("reset_rready",    32'(rready),    32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata,      32'd0);
        chk("reset_rsp_resp",  32'(rsp_resp),  32'd0);
        chk("prot_bits",       32'({awprot, arprot}), 32'd0);

        // Zero-wait write then readback.
        do_cmd(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 1'b1, 32'd0, 2'b00, 3);
        chk("aw_w_hs_cycle1", 32'({awvalid, awready, wvalid, wready}), 32'hF);
        wait_done(40);
        do_cmd(1'b0, 12'h004, 32'd0, 4'h0, 1'b1, 32'hDEADBEEF, 2'b00, 3);
        wait_done(40);

        // awready late by 4 cycles, partial strobes.
        aw_delay = 4;
        @(negedge clk); #1;
        cnt_aw = 0; cnt_w = 0; cnt_b = 0; cnt_rsp = 0;
        do_cmd(1'b1, 12'h008, 32'h12345678, 4'h3, 1'b1, 32'd0, 2'b00, 7);
        wait_done(40);
        chk("awvalid_cycles", 32'(cnt_aw), 32'd5);
        chk("wvalid_cycles",  32'(cnt_w),  32'd1);
        chk("b_handshakes",   32'(cnt_b),  32'd1);
        chk("rsp_pulses",     32'(cnt_rsp), 32'd1);
        aw_delay = 0;
        do_cmd(1'b0, 12'h008, 32'd0, 4'h0, 1'b1, 32'h00005678, 2'b00, 3);
        wait_done(40);

        // Slave error response passes through on both channels.
        do_cmd(1'b1, 12'h03C, 32'h0BADF00D, 4'hF, 1'b1, 32'd0, 2'b10, 3);
        wait_done(40);
        do_cmd(1'b0, 12'h03C, 32'd0, 4'h0, 1'b1, 32'h0BADF00D, 2'b10, 3);
        wait_done(40);

        // Read with rvalid late by 6 cycles.
        do_cmd(1'b1, 12'h018, 32'hCAFEF00D, 4'hF, 1'b1, 32'd0, 2'b00, 3);
        wait_done(40);
        r_delay = 6;
        do_cmd(1'b0, 12'h018, 32'd0, 4'h0, 1'b1, 32'hCAFEF00D, 2'b00, 9);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (!rready || cmd_ready) bad++;
        end
        chk("rdata_wait_rready_busy", 32'(bad), 32'd0);
        wait_done(40);
        r_delay = 0;
        repeat (3) @(negedge clk);
        chk("rsp_rdata_hold", rsp_rdata, 32'hCAFEF00D);
        chk("rsp_valid_single", 32'(rsp_valid), 32'd0);

        // Silent slave: watchdog abort.
        s_silent = 1'b1;
        do_cmd(1'b0, 12'h018, 32'd0, 4'h0, 1'b1, 32'd0, 2'b11, 16);
        repeat (15) @(negedge clk);
        chk("timeout_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("timeout_axi_idle", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
        @(negedge clk);
        chk("timeout_cmd_ready", 32'(cmd_ready), 32'd1);
        wait_done(40);

        // Stray responses while idle are ignored.
        force_b = 1'b1; force_r = 1'b1;
        @(negedge clk);
        chk("late_resp_readies", 32'({bready, rready}), 32'd0);
        @(negedge clk);
        force_b = 1'b0; force_r = 1'b0;
        repeat (3) @(negedge clk);
        s_silent = 1'b0;

        // Asynchronous reset mid-write.
        aw_delay = 10; w_delay = 10;
        do_cmd(1'b1, 12'h020, 32'h55AA55AA, 4'hF, 1'b0, 32'd0, 2'b00, 0);
        @(negedge clk);
        chk("pre_reset_valids", 32'({awvalid, wvalid}), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_valids", 32'({awvalid, wvalid}), 32'd0);
        aw_delay = 0; w_delay = 0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        do_cmd(1'b0, 12'h004, 32'd0, 4'h0, 1'b1, 32'hDEADBEEF, 2'b00, 3);
        wait_done(40);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/m_axil_cmd.md
M_AXIL_CMD -- requirements
Module: m_axil_cmd

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width (byte address is ADDR_WIDTH+2 bits; data fixed at 32 bits).
REQ-002 SHALL have parameter TIMEOUT, default 1024, cycles allowed per transaction before abort.
REQ-003 SHALL have port axi_clock  input  1  the single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr  input  ADDR_WIDTH+2  byte address.
REQ-009 SHALL have port cmd_wdata  input  32  write data.
REQ-010 SHALL have port cmd_wstrb  input  4  write byte strobes.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  32  read data, valid with rsp_valid.
REQ-013 SHALL have port rsp_resp  output  2  AXI response; 2'b11 on timeout.
REQ-014 SHALL have master AXI4-Lite write-address ports m_axil_awaddr (out, ADDR_WIDTH+2), m_axil_awprot (out, 3), m_axil_awvalid (out, 1), m_axil_awready (in, 1).
REQ-015 SHALL have write-data ports m_axil_wdata (out, 32), m_axil_wstrb (out, 4), m_axil_wvalid (out, 1), m_axil_wready (in, 1).
REQ-016 SHALL have write-response ports m_axil_bresp (in, 2), m_axil_bvalid (in, 1), m_axil_bready (out, 1).
REQ-017 SHALL have read-address ports m_axil_araddr (out, ADDR_WIDTH+2), m_axil_arprot (out, 3), m_axil_arvalid (out, 1), m_axil_arready (in, 1).
REQ-018 SHALL have read-data ports m_axil_rdata (in, 32), m_axil_rresp (in, 2), m_axil_rvalid (in, 1), m_axil_rready (out, 1).

Function
REQ-019 SHALL implement states IDLE, WADDR_DATA, WRESP, RADDR, RDATA, DONE; one transaction outstanding at a time.
REQ-020 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready SHALL latch addr/wdata/wstrb/write and go to WADDR_DATA (write) or RADDR (read).
REQ-021 In WADDR_DATA SHALL assert awvalid and wvalid together from the next cycle; each SHALL drop independently the cycle after its own ready handshake; payloads SHALL stay stable while valid; transition to WRESP when both handshakes are done (same cycle allowed).
REQ-022 SHALL hold bready=1 only in WRESP; on bvalid SHALL capture bresp, set rsp_rdata=0, go to DONE.
REQ-023 SHALL hold arvalid in RADDR until arready handshake, then go to RDATA with rready=1; on rvalid SHALL capture rdata/rresp, go to DONE.
REQ-024 SHALL pulse rsp_valid for exactly one cycle in DONE, then return to IDLE; rsp_rdata/rsp_resp SHALL hold until the next DONE.
REQ-025 Against a zero-wait slave (readies high, registered bvalid/rvalid), rsp_valid SHALL assert 3 cycles after command acceptance for both read and write.
REQ-026 awprot/arprot SHALL be constant 3'b000.
REQ-027 A 16-bit-saturating timeout counter SHALL clear on acceptance and increment in every non-IDLE/DONE cycle; on reaching TIMEOUT-1 SHALL deassert all AXI valids/readies, set rsp_resp=2'b11, rsp_rdata=0, go to DONE (fault recovery only; slave must then be reset).
REQ-028 Late bvalid/rvalid arriving in IDLE SHALL be ignored (bready/rready low).

Reset
REQ-029 While rst is high (asynchronous, mid-transaction included): state=IDLE, cmd_ready=1 after release, all AXI valids/readies=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, counter=0.

Verification
REQ-030 Write addr 0x004, data 0xDEADBEEF, strb 0xF, zero-wait slave -> aw/w handshake cycle 1, rsp_valid cycle 3, rsp_resp=0, register 1 reads back 0xDEADBEEF.
REQ-031 Write with awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 5 cycles, exactly one B handshake, one rsp_valid.
REQ-032 Read addr 0x018 with rvalid delayed 6 cycles -> rready high throughout, rsp_rdata equals slave data, no second command accepted meanwhile (cmd_ready=0).
REQ-033 Silent slave, TIMEOUT=16 -> rsp_valid at 16 cycles after acceptance with rsp_resp=2'b11, rsp_rdata=0, all valids low, cmd_ready=1 next cycle.
REQ-034 rst asserted while awvalid=1 -> awvalid/wvalid fall without a clock edge; after release cmd_ready=1 and next read completes normally.
